// File: rtl/axis_hdr_insert_gen.sv
// axis_hdr_insert_gen
// Prepends 0..DATA_BYTE_WD header bytes (taken per packet from a side channel)
// to a byte-packed AXI-Stream payload. Each payload beat is realigned through a
// residue register. A tail beat is emitted when the last beat overflows.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   valid_in/data_in/keep_in/last_in/ready_in      payload sink (MSB byte first)
//   valid_out/data_out/keep_out/last_out/ready_out output source (registered)
//   valid_insert/data_insert/keep_insert/byte_insert_cnt/ready_insert
//                       header side channel; header bytes are the low
//                       byte_insert_cnt bytes of data_insert, MSB-first
module axis_hdr_insert_gen #(
  parameter int unsigned DATA_WD      = 32,
  parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
  parameter int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  input  logic                    valid_insert,
  input  logic [DATA_WD-1:0]      data_insert,
  input  logic [DATA_BYTE_WD-1:0] keep_insert,
  input  logic [BYTE_CNT_WD:0]    byte_insert_cnt,
  output logic                    ready_insert
);

  localparam int unsigned CNT_WD = BYTE_CNT_WD + 1;
  localparam int unsigned SUM_WD = BYTE_CNT_WD + 2;
  localparam int unsigned SH_WD  = $clog2(DATA_WD) + 2;

  localparam logic [CNT_WD-1:0] FULL_CNT = CNT_WD'(DATA_BYTE_WD);
  localparam logic [SUM_WD-1:0] FULL_SUM = SUM_WD'(DATA_BYTE_WD);

  typedef enum logic [1:0] {
    HDR  = 2'd0,
    BODY = 2'd1,
    TAIL = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Residue bytes are kept left-aligned; bytes beyond res_cnt are always zero.
  logic [DATA_WD-1:0]   res_data;
  logic [CNT_WD-1:0]    res_cnt;
  logic [DATA_WD-1:0]   res_data_nxt;
  logic [CNT_WD-1:0]    res_cnt_nxt;

  logic                    ld;
  logic                    hdr_acc;
  logic                    beat_acc;
  logic [CNT_WD-1:0]       hdr_cnt;
  logic [SH_WD-1:0]        hdr_sh;
  logic [DATA_WD-1:0]      hdr_data;
  logic [CNT_WD-1:0]       in_cnt;
  logic [DATA_WD-1:0]      din_m;
  logic [SH_WD-1:0]        in_sh;
  logic [2*DATA_WD-1:0]    cat;
  logic [SUM_WD-1:0]       total;
  logic                    overflow;

  logic                    emit;
  logic [DATA_WD-1:0]      out_data_nxt;
  logic [DATA_BYTE_WD-1:0] out_keep_nxt;
  logic                    out_last_nxt;

  logic                    unused_keep_insert;

  // Keep mask with the top n bits set (n may equal DATA_BYTE_WD).
  function automatic logic [DATA_BYTE_WD-1:0] top_keep(input logic [SUM_WD-1:0] n);
    logic [DATA_BYTE_WD-1:0] ones;
    ones = '1;
    return ~(ones >> n);
  endfunction

  assign unused_keep_insert = ^keep_insert;

  assign ld           = !valid_out || ready_out;
  assign ready_insert = rst_n && (state == HDR);
  assign ready_in     = rst_n && (state == BODY) && ld;
  assign hdr_acc      = valid_insert && ready_insert;
  assign beat_acc     = valid_in && ready_in;

  // Header: clamp the count and left-align its low bytes.
  assign hdr_cnt  = (byte_insert_cnt > FULL_CNT) ? FULL_CNT : byte_insert_cnt;
  assign hdr_sh   = (SH_WD'(DATA_BYTE_WD) - SH_WD'(hdr_cnt)) << 3;
  assign hdr_data = data_insert << hdr_sh;

  // Payload byte count and zero-fill of bytes outside keep_in.
  always_comb begin
    in_cnt = '0;
    din_m  = '0;
    for (int unsigned i = 0; i < DATA_BYTE_WD; i++) begin
      in_cnt = in_cnt + CNT_WD'(keep_in[i]);
      if (keep_in[i]) din_m[8*i +: 8] = data_in[8*i +: 8];
    end
  end

  // Residue followed by the incoming bytes; upper half is the outgoing beat.
  assign in_sh    = SH_WD'(res_cnt) << 3;
  assign cat      = {res_data, {DATA_WD{1'b0}}} | ({din_m, {DATA_WD{1'b0}}} >> in_sh);
  assign total    = SUM_WD'(res_cnt) + SUM_WD'(in_cnt);
  assign overflow = total > FULL_SUM;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= HDR;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      HDR:     if (hdr_acc) state_nxt = BODY;
      BODY:    if (beat_acc && last_in) state_nxt = overflow ? TAIL : HDR;
      TAIL:    if (ld) state_nxt = HDR;
      default: state_nxt = HDR;
    endcase
  end

  // Output and residue update logic.
  always_comb begin
    emit         = 1'b0;
    out_data_nxt = '0;
    out_keep_nxt = '0;
    out_last_nxt = 1'b0;
    res_data_nxt = res_data;
    res_cnt_nxt  = res_cnt;
    case (state)
      HDR: begin
        if (hdr_acc) begin
          res_data_nxt = hdr_data;
          res_cnt_nxt  = hdr_cnt;
        end
      end
      BODY: begin
        if (beat_acc) begin
          emit         = 1'b1;
          out_data_nxt = cat[2*DATA_WD-1:DATA_WD];
          if (!last_in) begin
            out_keep_nxt = '1;
            res_data_nxt = cat[DATA_WD-1:0];
          end else if (!overflow) begin
            out_keep_nxt = top_keep(total);
            out_last_nxt = 1'b1;
            res_data_nxt = '0;
            res_cnt_nxt  = '0;
          end else begin
            out_keep_nxt = '1;
            res_data_nxt = cat[DATA_WD-1:0];
            res_cnt_nxt  = CNT_WD'(total - FULL_SUM);
          end
        end
      end
      TAIL: begin
        if (ld) begin
          emit         = 1'b1;
          out_data_nxt = res_data;
          out_keep_nxt = top_keep(SUM_WD'(res_cnt));
          out_last_nxt = 1'b1;
          res_data_nxt = '0;
          res_cnt_nxt  = '0;
        end
      end
      default: begin
        res_data_nxt = '0;
        res_cnt_nxt  = '0;
      end
    endcase
  end

  // Residue and output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_data  <= '0;
      res_cnt   <= '0;
      valid_out <= 1'b0;
      data_out  <= '0;
      keep_out  <= '0;
      last_out  <= 1'b0;
    end else begin
      res_data <= res_data_nxt;
      res_cnt  <= res_cnt_nxt;
      if (ld) begin
        valid_out <= emit;
        data_out  <= out_data_nxt;
        keep_out  <= out_keep_nxt;
        last_out  <= out_last_nxt;
      end
    end
  end

endmodule
